// File: rtl/debug_reader.sv
// Memory-mapped debug input peripheral: host bytes are buffered in a FIFO and
// read by tile software as DATA/STATUS/CTRL/ID registers, with an optional level irq.
module debug_reader #(
    parameter logic [15:0] ADDRESS    = 16'h0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        we_i,
    input  logic [23:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [23:0]   A_DATA   = 24'h000000;
    localparam logic [23:0]   A_STATUS = 24'h000004;
    localparam logic [23:0]   A_CTRL   = 24'h000008;
    localparam logic [23:0]   A_ID     = 24'h00000C;
    localparam logic [AW:0]   DEPTH_C  = FIFO_DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx;
    logic [AW:0]   count_q, count_d;
    logic          irq_en_q, irq_en_d;
    logic [31:0]   data_q, data_d;

    logic empty, full, rd_en, wr_en, flush, pop, push;

    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_C);
    assign rx_ready_o = !full && !rst_i;
    assign push       = rx_valid_i && rx_ready_o;
    assign rd_en      = en_i && !we_i;
    assign wr_en      = en_i && we_i;
    assign flush      = wr_en && (addr_i == A_CTRL) && data_i[1];
    assign pop        = rd_en && (addr_i == A_DATA) && !empty;
    assign irq_o      = irq_en_q && !empty;
    assign data_o     = data_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        irq_en_d = irq_en_q;
        data_d   = data_q;
        wr_idx   = wr_ptr_q;

        if (wr_en && addr_i == A_CTRL) begin
            irq_en_d = data_i[0];
        end

        if (rd_en) begin
            case (addr_i)
                A_DATA:   data_d = empty ? 32'h0 : {1'b1, 23'b0, mem_q[rd_ptr_q]};
                A_STATUS: data_d = {15'b0, 9'(count_q), 6'b0, full, !empty};
                A_CTRL:   data_d = {31'b0, irq_en_q};
                A_ID:     data_d = {16'h0000, ADDRESS};
                default:  data_d = 32'h0;
            endcase
        end

        // Flush clears the FIFO before a same-cycle push lands in slot 0.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            wr_idx   = '0;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
        end

        if (push) begin
            wr_ptr_d = wr_idx + PTR_ONE;
            count_d  = count_d + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_idx] <= rx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            irq_en_q <= 1'b0;
            data_q   <= 32'h0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            irq_en_q <= irq_en_d;
            data_q   <= data_d;
        end
    end
endmodule

// File: tb/tb_debug_reader.sv
// Randomized scoreboard bench for debug_reader: a queue-based model predicts read
// data, irq and ready; a monitor checks data_o after every clock edge.
module tb_debug_reader;
    localparam int          DEPTH = 16;
    localparam logic [15:0] ADDR  = 16'h0203;

    logic        clk_i = 1'b0;
    logic        rst_i, en_i, we_i, rx_valid_i, irq_o, rx_ready_o;
    logic [23:0] addr_i;
    logic [31:0] data_i, data_o;
    logic [7:0]  rx_data_i;

    debug_reader #(.ADDRESS(ADDR), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o), .irq_o(irq_o),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  model_q[$];
    bit          model_irq_en = 1'b0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    // Applies one cycle of stimulus, advances the model, and checks irq/ready after the edge.
    task automatic cyc(input bit en, input bit we, input logic [23:0] addr, input logic [31:0] wd,
                       input bit rxv, input logic [7:0] rxd, input bit rst, output bit accepted);
        logic [31:0] val;
        bit          can_push;
        int          n;
        en_i = en; we_i = we; addr_i = addr; data_i = wd;
        rx_valid_i = rxv; rx_data_i = rxd; rst_i = rst;
        accepted = 1'b0;
        if (rst) begin
            model_q.delete();
            model_irq_en = 1'b0;
        end else begin
            n        = model_q.size();
            can_push = n < DEPTH;
            if (en && !we) begin
                val = 32'h0;
                case (addr)
                    24'h000000: if (n > 0) val = 32'h8000_0000 | 32'(model_q.pop_front());
                    24'h000004: val = (32'(n) << 8) | ((n == DEPTH) ? 32'h2 : 32'h0) | ((n > 0) ? 32'h1 : 32'h0);
                    24'h000008: val = {31'b0, model_irq_en};
                    24'h00000C: val = {16'h0000, ADDR};
                    default:    val = 32'h0;
                endcase
                exp_q.push_back(val);
            end
            if (en && we && addr == 24'h000008) begin
                model_irq_en = wd[0];
                if (wd[1]) model_q.delete();
            end
            if (rxv && can_push) begin
                model_q.push_back(rxd);
                accepted = 1'b1;
            end
        end
        @(posedge clk_i);
        #1;
        chk("rx_ready", {31'b0, rx_ready_o}, {31'b0, (!rst && model_q.size() < DEPTH)});
        chk("irq", {31'b0, irq_o}, {31'b0, (model_irq_en && model_q.size() > 0)});
        $display("cyc t=%0t en=%0b we=%0b addr=%06h wd=%08h rxv=%0b rxd=%02h rst=%0b acc=%0b data_o=%08h",
                 $time, en, we, addr, wd, rxv, rxd, rst, accepted, data_o);
    endtask

    task automatic idle();
        bit a;
        cyc(0, 0, 24'h0, 32'h0, 0, 8'h00, 0, a);
    endtask

    task automatic rd(input logic [23:0] addr);
        bit a;
        cyc(1, 0, addr, 32'h0, 0, 8'h00, 0, a);
    endtask

    task automatic wr(input logic [23:0] addr, input logic [31:0] d);
        bit a;
        cyc(1, 1, addr, d, 0, 8'h00, 0, a);
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit a;
        a = 1'b0;
        for (int k = 0; k < 40 && !a; k++) cyc(0, 0, 24'h0, 32'h0, 1, b, 0, a);
        chk("push_accept_bound", {31'b0, a}, 32'h1);
    endtask

    // Monitor: every read that fires at an edge pops one expectation; data_o must hold otherwise.
    initial begin : monitor
        logic [31:0] last;
        bit          fired, was_rst;
        last = 32'h0;
        forever begin
            @(posedge clk_i);
            fired   = en_i && !we_i && !rst_i;
            was_rst = rst_i;
            #1;
            if (was_rst) begin
                last = 32'h0;
            end else if (fired) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_underflow actual=read required=expectation");
                end else begin
                    last = exp_q.pop_front();
                end
            end
            chk("data_o", data_o, last);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit          a;
        logic [23:0] addrs [6];
        addrs[0] = 24'h000000; addrs[1] = 24'h000004; addrs[2] = 24'h000008;
        addrs[3] = 24'h00000C; addrs[4] = 24'h000010; addrs[5] = 24'h100000;

        cyc(0, 0, 24'h0, 32'h0, 0, 8'h00, 1, a);
        cyc(0, 0, 24'h0, 32'h0, 0, 8'h00, 1, a);
        idle();
        rd(24'h000004);
        rd(24'h00000C);
        rd(24'h000020);

        push_byte(8'h48);
        push_byte(8'h69);
        rd(24'h0); rd(24'h0); rd(24'h0);
        rd(24'h000004);

        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        cyc(0, 0, 24'h0, 32'h0, 1, 8'hAA, 0, a);
        chk("full_hold", {31'b0, a}, 32'h0);
        cyc(1, 0, 24'h000004, 32'h0, 1, 8'hAA, 0, a);
        chk("full_hold_status", {31'b0, a}, 32'h0);
        cyc(1, 0, 24'h000000, 32'h0, 1, 8'hAA, 0, a);
        chk("full_hold_pop", {31'b0, a}, 32'h0);
        cyc(0, 0, 24'h0, 32'h0, 1, 8'hAA, 0, a);
        chk("aa_accept", {31'b0, a}, 32'h1);
        for (int i = 0; i < DEPTH; i++) rd(24'h0);
        idle();

        wr(24'h000008, 32'h1);
        push_byte(8'h41);
        rd(24'h0);
        wr(24'h000008, 32'h0);
        push_byte(8'h42);
        idle();
        rd(24'h0);

        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        cyc(1, 1, 24'h000008, 32'h2, 1, 8'h7E, 0, a);
        rd(24'h000004);
        rd(24'h0);
        rd(24'h000008);

        wr(24'h000008, 32'h1);
        for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i));
        cyc(1, 0, 24'h0, 32'h0, 0, 8'h00, 1, a);
        idle();
        rd(24'h000004);
        rd(24'h000008);
        wr(24'h000004, 32'hFFFF_FFFF);
        wr(24'h00000C, 32'hFFFF_FFFF);
        rd(24'h00000C);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0),
                addrs[$urandom_range(0, 5)], $urandom,
                ($urandom_range(0, 2) != 0), 8'($urandom),
                ($urandom_range(0, 99) == 0), a);
        end
        idle();
        idle();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
